calc_key_entry: RTL and testbench
=================================

CALC_KEY_ENTRY -- requirements
Module: calc_key_entry

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port key_valid  input  1  one-cycle pulse from the PS/2 decoder on every make or break event.
REQ-004 SHALL have port last_change  input  9  scancode of the event; bit 8 set for E0-extended codes.
REQ-005 SHALL have port key_down  input  512  per-code pressed map from the PS/2 decoder.
REQ-006 SHALL have port val_a  output  8  operand A as two BCD digits {tens, ones}.
REQ-007 SHALL have port val_b  output  8  operand B as two BCD digits {tens, ones}.
REQ-008 SHALL have port op  output  2  operator: 00 add, 01 sub, 10 mul.
REQ-009 SHALL have port calc_go  output  1  one-cycle pulse when an expression is committed.
REQ-010 SHALL have port disp_digits  output  16  four BCD nibbles for the scanner, MSN leftmost; 4'hF = blank.
REQ-011 SHALL have port curr_state  output  3  state encoding, for LEDs.

Function
REQ-012 SHALL treat an event as a press only when key_valid=1 and key_down[last_change]=1; releases only re-arm.
REQ-013 SHALL hold the 9-bit code of the last accepted press plus an armed flag; a press equal to that code while disarmed (typematic repeat) SHALL be ignored; a release of that code SHALL re-arm.
REQ-014 SHALL decode digits 0-9 from codes 045,016,01E,026,025,02E,036,03D,03E,046; add 079, sub 07B, mul 07C; enter 05A or 15A; clear 076; all others ignored.
REQ-015 SHALL update every output on the cycle after the accepted key_valid cycle (latency 1).
REQ-016 SHALL implement states IDLE=0, ENTER_A=1, OP_SET=2, ENTER_B=3, RESULT=4; other encodings SHALL return to IDLE.
REQ-017 IDLE: digit -> val_a={0,d}, cnt_a=1, ENTER_A; other keys ignored.
REQ-018 ENTER_A: digit with cnt_a=1 -> val_a={ones,d}, cnt_a=2; digit with cnt_a=2 ignored (no wrap); operator -> set op, OP_SET; enter ignored.
REQ-019 OP_SET: operator -> replace op; digit -> val_b={0,d}, cnt_b=1, ENTER_B; enter ignored.
REQ-020 ENTER_B: digits as REQ-018 on val_b/cnt_b; operator ignored; enter -> calc_go=1 for exactly one cycle, RESULT.
REQ-021 RESULT: val_a, val_b, op SHALL hold; digit -> clear val_b/cnt_b, load val_a as in IDLE, ENTER_A; enter and operators ignored.
REQ-022 Clear code in any state SHALL zero val_a, val_b, counts, op and go to IDLE next cycle.
REQ-023 disp_digits: IDLE and RESULT all 4'hF; ENTER_A/OP_SET show val_a right-justified with unused positions blank; ENTER_B shows val_b likewise.
REQ-024 calc_go SHALL be 0 in every cycle other than the one specified in REQ-020.

Reset
REQ-025 rst=1 SHALL force curr_state=IDLE, val_a=0, val_b=0, op=00, calc_go=0, disp_digits=16'hFFFF, counts=0, armed=1, last code=0.
REQ-026 rst SHALL take priority over a simultaneous key_valid; an event in the rst cycle SHALL be discarded.
REQ-027 rst asserted mid-entry SHALL abandon the entry with no calc_go pulse.

Structure
REQ-028 A shared package calc_pkg SHALL hold the scancode constants, the state encodings and the op codes.
REQ-029 A combinational sub-module scancode_to_digit SHALL map a 9-bit code to {is_digit, digit[3:0]}.
REQ-030 The state register, operand registers and repeat filter SHALL live in calc_key_entry.

Verification
REQ-031 Press/release 1,2,+,3,4,Enter -> val_a=8'h12, val_b=8'h34, op=00, one calc_go pulse, curr_state=4.
REQ-032 Press 5 held with three repeated make events, then release -> val_a=8'h05, cnt_a=1, disp_digits=16'hFFF5.
REQ-033 Press 9,8,7 -> val_a=8'h98, the third digit is ignored; then -, * -> op=10, curr_state=2.
REQ-034 Press 4,+,Enter -> no calc_go, curr_state stays 2; then Esc -> all zero, IDLE.
REQ-035 rst in the same cycle as the Enter key_valid during ENTER_B -> no calc_go, reset values next cycle.
REQ-036 Press E0-5A (Enter) completing 7*6 -> calc_go pulse; then digit 3 -> val_a=8'h03, val_b=0, ENTER_A.

Source files
------------

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator key-entry slice: PS/2 scancode
// constants (9-bit, bit 8 = E0-extended), the entry FSM state encoding,
// operator codes and the display formatting helper.
// ---------------------------------------------------------------------------
package calc_pkg;

  // Digit scancodes (main keyboard row)
  localparam logic [8:0] SC_0        = 9'h045;
  localparam logic [8:0] SC_1        = 9'h016;
  localparam logic [8:0] SC_2        = 9'h01E;
  localparam logic [8:0] SC_3        = 9'h026;
  localparam logic [8:0] SC_4        = 9'h025;
  localparam logic [8:0] SC_5        = 9'h02E;
  localparam logic [8:0] SC_6        = 9'h036;
  localparam logic [8:0] SC_7        = 9'h03D;
  localparam logic [8:0] SC_8        = 9'h03E;
  localparam logic [8:0] SC_9        = 9'h046;

  // Operator, enter and clear scancodes
  localparam logic [8:0] SC_ADD      = 9'h079;
  localparam logic [8:0] SC_SUB      = 9'h07B;
  localparam logic [8:0] SC_MUL      = 9'h07C;
  localparam logic [8:0] SC_ENTER    = 9'h05A;
  localparam logic [8:0] SC_KP_ENTER = 9'h15A;
  localparam logic [8:0] SC_CLEAR    = 9'h076;

  localparam logic [15:0] DISP_BLANK = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_OP_SET  = 3'd2,
    ST_ENTER_B = 3'd3,
    ST_RESULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_t;

  // Right-justify a two-digit BCD operand on four nibbles; positions beyond
  // the number of digits typed so far stay blank (4'hF).
  function automatic logic [15:0] disp_of(input logic [7:0] val, input logic [1:0] cnt);
    logic [15:0] res;
    case (cnt)
      2'd1:    res = {12'hFFF, val[3:0]};
      2'd2:    res = {8'hFF, val};
      default: res = DISP_BLANK;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc_key_entry_scancode_to_digit.sv
// ---------------------------------------------------------------------------
// scancode_to_digit
// Combinational decode of a 9-bit scancode into a decimal digit.
//   i_code     : 9-bit scancode (bit 8 = E0-extended)
//   o_is_digit : 1 when i_code is one of the ten digit keys
//   o_digit    : decoded value 0-9 (0 when not a digit)
// E0-prefixed codes never match, since all 9 bits are compared.
// ---------------------------------------------------------------------------
module scancode_to_digit
  import calc_pkg::*;
(
  input  logic [8:0] i_code,
  output logic       o_is_digit,
  output logic [3:0] o_digit
);

  // Scancode lookup
  always_comb begin
    o_is_digit = 1'b1;
    o_digit    = 4'd0;
    case (i_code)
      SC_0:    o_digit = 4'd0;
      SC_1:    o_digit = 4'd1;
      SC_2:    o_digit = 4'd2;
      SC_3:    o_digit = 4'd3;
      SC_4:    o_digit = 4'd4;
      SC_5:    o_digit = 4'd5;
      SC_6:    o_digit = 4'd6;
      SC_7:    o_digit = 4'd7;
      SC_8:    o_digit = 4'd8;
      SC_9:    o_digit = 4'd9;
      default: begin
        o_is_digit = 1'b0;
        o_digit    = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/calc_key_entry.sv
// ---------------------------------------------------------------------------
// calc_key_entry
// Turns PS/2 key events into a two-operand calculator expression.
//   clk, rst     : clock, synchronous active-high reset
//   key_valid    : one-cycle event strobe (make or break)
//   last_change  : 9-bit scancode of the event
//   key_down     : 512-bit pressed map from the decoder
//   val_a, val_b : operands, two BCD digits each
//   op           : 00 add, 01 sub, 10 mul
//   calc_go      : one-cycle pulse when Enter commits an expression
//   disp_digits  : four BCD nibbles for the display scanner (F = blank)
//   curr_state   : FSM state encoding for LEDs
// All outputs are registered and change one cycle after the accepted event.
// ---------------------------------------------------------------------------
module calc_key_entry
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  output logic [7:0]   val_a,
  output logic [7:0]   val_b,
  output logic [1:0]   op,
  output logic         calc_go,
  output logic [15:0]  disp_digits,
  output logic [2:0]   curr_state
);

  state_t      r_state, w_state_next;
  logic [7:0]  r_val_a, w_val_a_next;
  logic [7:0]  r_val_b, w_val_b_next;
  logic [1:0]  r_cnt_a, w_cnt_a_next;
  logic [1:0]  r_cnt_b, w_cnt_b_next;
  op_t         r_op, w_op_next;
  logic        r_calc_go, w_calc_go_next;
  logic [15:0] r_disp, w_disp_next;
  logic [8:0]  r_last_code, w_last_code_next;
  logic        r_armed, w_armed_next;

  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic        w_is_op;
  op_t         w_op_code;
  logic        w_is_enter;
  logic        w_is_clear;
  logic        w_is_make;
  logic        w_same_code;
  logic        w_press;
  logic        w_rearm;

  scancode_to_digit u_digit (
    .i_code     (last_change),
    .o_is_digit (w_is_digit),
    .o_digit    (w_digit)
  );

  assign w_is_make   = key_valid & key_down[last_change];
  assign w_same_code = (last_change == r_last_code);
  // A make of the remembered code while disarmed is typematic repeat.
  assign w_press     = w_is_make & ~(w_same_code & ~r_armed);
  assign w_rearm     = key_valid & ~key_down[last_change] & w_same_code;
  assign w_is_enter  = (last_change == SC_ENTER) | (last_change == SC_KP_ENTER);
  assign w_is_clear  = (last_change == SC_CLEAR);

  // Operator key decode
  always_comb begin
    w_is_op   = 1'b1;
    w_op_code = OP_ADD;
    case (last_change)
      SC_ADD:  w_op_code = OP_ADD;
      SC_SUB:  w_op_code = OP_SUB;
      SC_MUL:  w_op_code = OP_MUL;
      default: begin
        w_is_op   = 1'b0;
        w_op_code = OP_ADD;
      end
    endcase
  end

  // Repeat filter, entry FSM next state and next output values
  always_comb begin
    w_state_next     = r_state;
    w_val_a_next     = r_val_a;
    w_val_b_next     = r_val_b;
    w_cnt_a_next     = r_cnt_a;
    w_cnt_b_next     = r_cnt_b;
    w_op_next        = r_op;
    w_calc_go_next   = 1'b0;
    w_last_code_next = r_last_code;
    w_armed_next     = r_armed;
    w_disp_next      = DISP_BLANK;

    if (w_press) begin
      w_last_code_next = last_change;
      w_armed_next     = 1'b0;
    end else if (w_rearm) begin
      w_armed_next = 1'b1;
    end else begin
      w_armed_next = r_armed;
    end

    if (w_press && w_is_clear) begin
      w_state_next = ST_IDLE;
      w_val_a_next = 8'h00;
      w_val_b_next = 8'h00;
      w_cnt_a_next = 2'd0;
      w_cnt_b_next = 2'd0;
      w_op_next    = OP_ADD;
    end else if (w_press) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_digit) begin
            w_val_a_next = {4'h0, w_digit};
            w_cnt_a_next = 2'd1;
            w_state_next = ST_ENTER_A;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_ENTER_A: begin
          if (w_is_digit) begin
            // A third digit is dropped rather than scrolling the operand.
            if (r_cnt_a == 2'd1) begin
              w_val_a_next = {r_val_a[3:0], w_digit};
              w_cnt_a_next = 2'd2;
            end else begin
              w_cnt_a_next = r_cnt_a;
            end
          end else if (w_is_op) begin
            w_op_next    = w_op_code;
            w_state_next = ST_OP_SET;
          end else begin
            w_state_next = ST_ENTER_A;
          end
        end
        ST_OP_SET: begin
          if (w_is_op) begin
            w_op_next = w_op_code;
          end else if (w_is_digit) begin
            w_val_b_next = {4'h0, w_digit};
            w_cnt_b_next = 2'd1;
            w_state_next = ST_ENTER_B;
          end else begin
            w_state_next = ST_OP_SET;
          end
        end
        ST_ENTER_B: begin
          if (w_is_digit) begin
            if (r_cnt_b == 2'd1) begin
              w_val_b_next = {r_val_b[3:0], w_digit};
              w_cnt_b_next = 2'd2;
            end else begin
              w_cnt_b_next = r_cnt_b;
            end
          end else if (w_is_enter) begin
            w_calc_go_next = 1'b1;
            w_state_next   = ST_RESULT;
          end else begin
            w_state_next = ST_ENTER_B;
          end
        end
        ST_RESULT: begin
          // A new digit starts a fresh expression; op is kept.
          if (w_is_digit) begin
            w_val_b_next = 8'h00;
            w_cnt_b_next = 2'd0;
            w_val_a_next = {4'h0, w_digit};
            w_cnt_a_next = 2'd1;
            w_state_next = ST_ENTER_A;
          end else begin
            w_state_next = ST_RESULT;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else begin
      // Illegal encodings recover even without a key event.
      case (r_state)
        ST_IDLE, ST_ENTER_A, ST_OP_SET, ST_ENTER_B, ST_RESULT: w_state_next = r_state;
        default: w_state_next = ST_IDLE;
      endcase
    end

    case (w_state_next)
      ST_ENTER_A, ST_OP_SET: w_disp_next = disp_of(w_val_a_next, w_cnt_a_next);
      ST_ENTER_B:            w_disp_next = disp_of(w_val_b_next, w_cnt_b_next);
      default:               w_disp_next = DISP_BLANK;
    endcase
  end

  // State, operand, filter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_val_a     <= 8'h00;
      r_val_b     <= 8'h00;
      r_cnt_a     <= 2'd0;
      r_cnt_b     <= 2'd0;
      r_op        <= OP_ADD;
      r_calc_go   <= 1'b0;
      r_disp      <= DISP_BLANK;
      r_last_code <= 9'h000;
      r_armed     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_val_a     <= w_val_a_next;
      r_val_b     <= w_val_b_next;
      r_cnt_a     <= w_cnt_a_next;
      r_cnt_b     <= w_cnt_b_next;
      r_op        <= w_op_next;
      r_calc_go   <= w_calc_go_next;
      r_disp      <= w_disp_next;
      r_last_code <= w_last_code_next;
      r_armed     <= w_armed_next;
    end
  end

  assign val_a       = r_val_a;
  assign val_b       = r_val_b;
  assign op          = r_op;
  assign calc_go     = r_calc_go;
  assign disp_digits = r_disp;
  assign curr_state  = r_state;

endmodule

// File: tb/tb_calc_key_entry.sv
// Self-checking bench for calc_key_entry: directed scenarios plus a random
// key-event stream compared against an arithmetic model of the calculator.
module tb_calc_key_entry;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [8:0]   last_change = 9'h000;
  logic [511:0] key_down = '0;
  logic [7:0]   val_a, val_b;
  logic [1:0]   op;
  logic         calc_go;
  logic [15:0]  disp_digits;
  logic [2:0]   curr_state;

  always #5 clk = ~clk;

  calc_key_entry dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .val_a       (val_a),
    .val_b       (val_b),
    .op          (op),
    .calc_go     (calc_go),
    .disp_digits (disp_digits),
    .curr_state  (curr_state)
  );

  wire [37:0] obs = {val_a, val_b, op, calc_go, disp_digits, curr_state};

  int n_checks = 0;
  int n_pass   = 0;
  int go_seen  = 0;
  int go_expected = 0;

  // Reference model: operands kept as plain integers with a digit count.
  int m_phase, m_a, m_na, m_b, m_nb, m_op, m_last;
  bit m_armed, m_go;

  logic [8:0] dig_codes [10] = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025,
                                 9'h02E, 9'h036, 9'h03D, 9'h03E, 9'h046};

  always @(negedge clk) if (calc_go === 1'b1) go_seen++;

  function automatic int dig_of(input logic [8:0] c);
    for (int i = 0; i < 10; i++) if (dig_codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [15:0] shown(input int v, input int n);
    if (n == 1) return {12'hFFF, 4'(v % 10)};
    if (n == 2) return {8'hFF, bcd(v)};
    return 16'hFFFF;
  endfunction

  function automatic logic [37:0] model_outs();
    logic [15:0] d;
    if (m_phase == 1 || m_phase == 2) d = shown(m_a, m_na);
    else if (m_phase == 3)            d = shown(m_b, m_nb);
    else                              d = 16'hFFFF;
    return {bcd(m_a), bcd(m_b), 2'(m_op), m_go, d, 3'(m_phase)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_op = 0;
    m_last = 0; m_armed = 1'b1; m_go = 1'b0;
  endtask

  task automatic model_key(input logic [8:0] c);
    int d;
    d = dig_of(c);
    if (c == 9'h076) begin
      m_phase = 0; m_a = 0; m_na = 0; m_b = 0; m_nb = 0; m_op = 0;
    end else if (d >= 0) begin
      if (m_phase == 0) begin m_a = d; m_na = 1; m_phase = 1; end
      else if (m_phase == 1) begin if (m_na < 2) begin m_a = m_a * 10 + d; m_na++; end end
      else if (m_phase == 2) begin m_b = d; m_nb = 1; m_phase = 3; end
      else if (m_phase == 3) begin if (m_nb < 2) begin m_b = m_b * 10 + d; m_nb++; end end
      else begin m_b = 0; m_nb = 0; m_a = d; m_na = 1; m_phase = 1; end
    end else if (c == 9'h079 || c == 9'h07B || c == 9'h07C) begin
      if (m_phase == 1 || m_phase == 2) begin
        m_op = (c == 9'h079) ? 0 : (c == 9'h07B) ? 1 : 2;
        m_phase = 2;
      end
    end else if (c == 9'h05A || c == 9'h15A) begin
      if (m_phase == 3) begin m_go = 1'b1; m_phase = 4; go_expected++; end
    end
  endtask

  task automatic model_event(input logic [8:0] c, input logic down);
    m_go = 1'b0;
    if (down) begin
      if (!(int'(c) == m_last && !m_armed)) begin
        m_last = int'(c); m_armed = 1'b0;
        model_key(c);
      end
    end else if (int'(c) == m_last) begin
      m_armed = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_valid = 1'b0; key_down = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [8:0] c, input logic down);
    @(negedge clk);
    key_down[c] = down; last_change = c; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    model_event(c, down);
  endtask

  task automatic press(input logic [8:0] c);
    send(c, 1'b1);
    send(c, 1'b0);
  endtask

  task automatic test_reset();
    // key events during reset must be discarded
    @(negedge clk);
    rst = 1'b1; key_down[9'h045] = 1'b1; last_change = 9'h045; key_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; key_valid = 1'b0; key_down = '0;
    model_reset();
    n_checks++;
    if (obs !== {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0})
      $display("FAIL reset_state: got %h expected %h", obs, {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0});
    else n_pass++;
  endtask

  task automatic test_basic_expr();
    do_reset();
    press(9'h016); press(9'h01E);
    n_checks++;
    if (obs !== model_outs()) $display("FAIL basic_after_12: got %h expected %h", obs, model_outs());
    else n_pass++;
    press(9'h079); press(9'h026); press(9'h025);
    send(9'h05A, 1'b1);
    n_checks++;
    if (obs !== {8'h12, 8'h34, 2'b00, 1'b1, 16'hFFFF, 3'd4})
      $display("FAIL basic_go: got %h expected %h", obs, {8'h12, 8'h34, 2'b00, 1'b1, 16'hFFFF, 3'd4});
    else n_pass++;
    send(9'h05A, 1'b0);
    n_checks++;
    if (obs !== {8'h12, 8'h34, 2'b00, 1'b0, 16'hFFFF, 3'd4})
      $display("FAIL basic_go_one_cycle: got %h expected %h", obs, {8'h12, 8'h34, 2'b00, 1'b0, 16'hFFFF, 3'd4});
    else n_pass++;
  endtask

  task automatic test_repeat();
    do_reset();
    for (int i = 0; i < 4; i++) send(9'h02E, 1'b1);
    send(9'h02E, 1'b0);
    n_checks++;
    if (obs !== {8'h05, 8'h00, 2'b00, 1'b0, 16'hFFF5, 3'd1})
      $display("FAIL repeat_filter: got %h expected %h", obs, {8'h05, 8'h00, 2'b00, 1'b0, 16'hFFF5, 3'd1});
    else n_pass++;
    press(9'h02E);
    n_checks++;
    if (obs !== {8'h55, 8'h00, 2'b00, 1'b0, 16'hFF55, 3'd1})
      $display("FAIL repeat_rearm: got %h expected %h", obs, {8'h55, 8'h00, 2'b00, 1'b0, 16'hFF55, 3'd1});
    else n_pass++;
  endtask

  task automatic test_overflow_ops();
    do_reset();
    press(9'h046); press(9'h03E); press(9'h03D);
    n_checks++;
    if (obs !== {8'h98, 8'h00, 2'b00, 1'b0, 16'hFF98, 3'd1})
      $display("FAIL third_digit_ignored: got %h expected %h", obs, {8'h98, 8'h00, 2'b00, 1'b0, 16'hFF98, 3'd1});
    else n_pass++;
    press(9'h07B); press(9'h07C);
    n_checks++;
    if (obs !== {8'h98, 8'h00, 2'b10, 1'b0, 16'hFF98, 3'd2})
      $display("FAIL op_replace: got %h expected %h", obs, {8'h98, 8'h00, 2'b10, 1'b0, 16'hFF98, 3'd2});
    else n_pass++;
  endtask

  task automatic test_enter_opset_clear();
    int go_before;
    do_reset();
    go_before = go_seen;
    press(9'h025); press(9'h079); press(9'h05A);
    n_checks++;
    if (obs !== {8'h04, 8'h00, 2'b00, 1'b0, 16'hFFF4, 3'd2} || go_seen != go_before)
      $display("FAIL enter_in_opset: got %h go=%0d expected %h go=%0d", obs, go_seen,
               {8'h04, 8'h00, 2'b00, 1'b0, 16'hFFF4, 3'd2}, go_before);
    else n_pass++;
    press(9'h076);
    n_checks++;
    if (obs !== {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0})
      $display("FAIL clear: got %h expected %h", obs, {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0});
    else n_pass++;
  endtask

  task automatic test_rst_on_enter();
    int go_before;
    do_reset();
    press(9'h016); press(9'h07C); press(9'h01E);
    go_before = go_seen;
    @(negedge clk);
    key_down[9'h05A] = 1'b1; last_change = 9'h05A; key_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (obs !== {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0} || go_seen != go_before)
      $display("FAIL rst_beats_enter: got %h go=%0d expected %h go=%0d", obs, go_seen,
               {8'h00, 8'h00, 2'b00, 1'b0, 16'hFFFF, 3'd0}, go_before);
    else n_pass++;
    send(9'h05A, 1'b0);
  endtask

  task automatic test_extended_enter();
    do_reset();
    press(9'h03D); press(9'h07C); press(9'h036);
    send(9'h15A, 1'b1);
    n_checks++;
    if (obs !== {8'h07, 8'h06, 2'b10, 1'b1, 16'hFFFF, 3'd4})
      $display("FAIL e0_enter_go: got %h expected %h", obs, {8'h07, 8'h06, 2'b10, 1'b1, 16'hFFFF, 3'd4});
    else n_pass++;
    send(9'h15A, 1'b0);
    press(9'h026);
    n_checks++;
    if (obs !== {8'h03, 8'h00, 2'b10, 1'b0, 16'hFFF3, 3'd1})
      $display("FAIL result_new_digit: got %h expected %h", obs, {8'h03, 8'h00, 2'b10, 1'b0, 16'hFFF3, 3'd1});
    else n_pass++;
  endtask

  task automatic test_random();
    logic [8:0] c;
    logic       dn;
    int         r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 19);
        if (r < 10)       c = dig_codes[r];
        else if (r == 10) c = 9'h079;
        else if (r == 11) c = 9'h07B;
        else if (r == 12) c = 9'h07C;
        else if (r == 13) c = 9'h05A;
        else if (r == 14) c = 9'h15A;
        else if (r == 15) c = ($urandom_range(0, 3) == 0) ? 9'h076 : 9'h05A;
        else              c = 9'($urandom_range(0, 511));
        dn = key_down[c] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
        send(c, dn);
        n_checks++;
        if (obs !== model_outs())
          $display("FAIL random_step%0d code=%h down=%0d: got %h expected %h", i, c, dn, obs, model_outs());
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_expr();
    test_repeat();
    test_overflow_ops();
    test_enter_opset_clear();
    test_rst_on_enter();
    test_extended_enter();
    test_random();
    @(negedge clk);
    n_checks++;
    if (go_seen != go_expected)
      $display("FAIL calc_go_pulse_count: got %0d expected %0d", go_seen, go_expected);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
